tlk2711_tx_link: RTL and testbench

Transmit-side link for the TLK2711 SERDES. On a start pulse it fetches a packet from DDR through the DMA read-command/read-data interface, splits it into fixed-size frames, and drives the TLK2711 parallel TX port. Each frame is SOF, header, payload and EOF, in the framing that `tlk2711_rx_link` decodes. It sits between the AXI DMA read engine and the TLK2711 TX pins, and raises an interrupt when the tail frame has been sent.

---
 rtl/tlk2711_tx_link.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_tlk2711_tx_link.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_link.sv
// ---------------------------------------------------------------------------
// tlk2711_tx_link
//
// Transmit-side link for the TLK2711 SERDES. A start pulse launches a packet
// transfer: the packet is pulled from DDR one frame at a time through the DMA
// read-command / read-data interface, staged in a small beat buffer, and then
// streamed out of the TLK2711 parallel TX port as
//    SOF, 5 header words, 436 payload words, EOF   (443 words per frame)
// Idle words (C5BC with K on the LSB) fill every non-frame cycle. After the
// tail frame's EOF a one-cycle interrupt is raised.
//
// Ports
//    clk, rst_n          link clock, asynchronous active-low reset
//    i_soft_rst          synchronous clear back to idle, buffer flushed
//    i_tx_start          one-cycle start pulse (ignored while busy)
//    i_tx_base_addr      8-byte aligned packet address in DDR
//    i_tx_packet_len     packet length in bytes (0 is ignored)
//    o_rd_cmd_req/ack    DMA read command handshake, data = {addr, byte_len}
//    i_dma_rd_valid/...  DMA read beats, 64 bits each, ready only while fetching
//    o_tx_busy           packet in progress
//    o_tx_interrupt      one-cycle pulse the cycle after the tail EOF
//    o_tx_frame_cnt      frames sent so far in the current packet
//    o_2711_*            TLK2711 TX word and K-character flags
// ---------------------------------------------------------------------------
module tlk2711_tx_link #(
    parameter int ADDR_WIDTH = 32,
    parameter int DLEN_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int IDLE_GAP   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_soft_rst,
    input  logic                             i_tx_start,
    input  logic [ADDR_WIDTH-1:0]            i_tx_base_addr,
    input  logic [31:0]                      i_tx_packet_len,
    output logic                             o_rd_cmd_req,
    input  logic                             i_rd_cmd_ack,
    output logic [ADDR_WIDTH+DLEN_WIDTH-1:0] o_rd_cmd_data,
    input  logic                             i_dma_rd_valid,
    output logic                             o_dma_rd_ready,
    input  logic [DATA_WIDTH-1:0]            i_dma_rd_data,
    output logic                             o_tx_busy,
    output logic                             o_tx_interrupt,
    output logic [15:0]                      o_tx_frame_cnt,
    output logic                             o_2711_tkmsb,
    output logic                             o_2711_tklsb,
    output logic [15:0]                      o_2711_txd
);

    // Framing constants shared with tlk2711_rx_link
    localparam logic [15:0] SOF_WORD      = 16'h5CFB;
    localparam logic [15:0] EOF_WORD      = 16'hFDFE;
    localparam logic [15:0] IDLE_WORD     = 16'hC5BC;
    localparam logic [15:0] FRAME_BYTES   = 16'd872;
    localparam logic [8:0]  LAST_HDR_WORD = 9'd5;
    localparam logic [8:0]  LAST_PAY_WORD = 9'd441;
    localparam int          GAP_W         = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_SOF,
        ST_HDR,
        ST_PAYLOAD,
        ST_EOF,
        ST_GAP
    } state_t;

    // Bytes carried by a frame, given the bytes still to send
    function automatic logic [15:0] frameBytes(input logic [31:0] rem);
        return (rem > {16'd0, FRAME_BYTES}) ? FRAME_BYTES : rem[15:0];
    endfunction

    // DMA byte length: valid bytes rounded up to whole 8-byte beats
    function automatic logic [DLEN_WIDTH-1:0] cmdLen(input logic [15:0] nBytes);
        logic [15:0] rounded;
        rounded = (nBytes + 16'd7) & 16'hFFF8;
        return DLEN_WIDTH'(rounded);
    endfunction

    state_t                            state_q;
    logic [31:0]                       remBytes_q;
    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [15:0]                       frameCnt_q;
    logic [8:0]                        word_q;
    logic [6:0]                        beatCnt_q;
    logic [GAP_W-1:0]                  gapCnt_q;
    logic                              irqPend_q;
    logic                              req_q;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0]  cmdData_q;
    logic                              ready_q;
    logic                              busy_q;
    logic                              irq_q;
    logic [15:0]                       txd_q;
    logic                              tkmsb_q;
    logic                              tklsb_q;

    logic [DATA_WIDTH-1:0]             beatBuf [128];

    logic [15:0]                       curBytes;
    logic                              isTail;
    logic [6:0]                        lastBeat;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0]  startCmd_d;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0]  nextCmd_d;
    logic                              beatFire;
    logic [8:0]                        payIdx;
    logic                              payValid;
    logic [DATA_WIDTH-1:0]             rdBeat;
    logic [15:0]                       laneWord;
    logic [15:0]                       hdrWord;

    // remBytes_q only changes at EOF, so everything derived from it is
    // stable for the whole of a frame (command, header, payload masking).
    assign curBytes   = frameBytes(remBytes_q);
    assign isTail     = (remBytes_q <= {16'd0, FRAME_BYTES});
    assign lastBeat   = 7'((curBytes - 16'd1) >> 3);
    assign startCmd_d = {i_tx_base_addr, cmdLen(frameBytes(i_tx_packet_len))};
    assign nextCmd_d  = {addr_q, cmdLen(curBytes)};
    assign beatFire   = (state_q == ST_FETCH) && ready_q && i_dma_rd_valid;

    // Payload word p lives in beat p/4, lane p%4 (lane 0 = bits [15:0]).
    // Anything past the valid byte count goes out as zero, which also hides
    // stale beats left over from a longer previous frame.
    assign payIdx   = word_q - 9'd6;
    assign payValid = ({6'd0, payIdx, 1'b0} < curBytes);
    assign rdBeat   = beatBuf[payIdx[8:2]];

    // Lane select within the current payload beat
    always_comb begin
        laneWord = rdBeat[15:0];
        case (payIdx[1:0])
            2'd1:    laneWord = rdBeat[31:16];
            2'd2:    laneWord = rdBeat[47:32];
            2'd3:    laneWord = rdBeat[63:48];
            default: laneWord = rdBeat[15:0];
        endcase
    end

    // Header words W1..W5; W2 and W4 are reserved zeros
    always_comb begin
        hdrWord = 16'h0000;
        case (word_q)
            9'd1:    hdrWord = frameCnt_q;
            9'd3:    hdrWord = {(isTail ? 8'h01 : 8'h00), 8'h00};
            9'd5:    hdrWord = curBytes;
            default: hdrWord = 16'h0000;
        endcase
    end

    // Beat buffer: written in arrival order during FETCH, read back by
    // payload index. The write pointer restarts every frame, so the buffer is
    // logically empty at each SOF and needs no reset of its own.
    always_ff @(posedge clk) begin
        if (beatFire) begin
            beatBuf[beatCnt_q] <= i_dma_rd_data;
        end
    end

    // Main link FSM. Every output is a register loaded here; the TX word
    // defaults to idle each cycle and only frame states override it, which
    // keeps a frame's 443 words back to back and makes a reset mid-frame fall
    // straight back to idle words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            remBytes_q <= '0;
            addr_q     <= '0;
            frameCnt_q <= '0;
            word_q     <= '0;
            beatCnt_q  <= '0;
            gapCnt_q   <= '0;
            irqPend_q  <= 1'b0;
            req_q      <= 1'b0;
            cmdData_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            txd_q      <= IDLE_WORD;
            tkmsb_q    <= 1'b0;
            tklsb_q    <= 1'b1;
        end else if (i_soft_rst) begin
            state_q    <= ST_IDLE;
            remBytes_q <= '0;
            addr_q     <= '0;
            frameCnt_q <= '0;
            word_q     <= '0;
            beatCnt_q  <= '0;
            gapCnt_q   <= '0;
            irqPend_q  <= 1'b0;
            req_q      <= 1'b0;
            cmdData_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            txd_q      <= IDLE_WORD;
            tkmsb_q    <= 1'b0;
            tklsb_q    <= 1'b1;
        end else begin
            txd_q   <= IDLE_WORD;
            tkmsb_q <= 1'b0;
            tklsb_q <= 1'b1;
            irq_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // The interrupt is held back one cycle so it lands the
                    // cycle after EOF; busy drops with it.
                    if (irqPend_q) begin
                        irqPend_q <= 1'b0;
                        irq_q     <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (i_tx_start && !busy_q && (i_tx_packet_len != 32'd0)) begin
                        remBytes_q <= i_tx_packet_len;
                        addr_q     <= i_tx_base_addr;
                        frameCnt_q <= '0;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        cmdData_q  <= startCmd_d;
                        state_q    <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (i_rd_cmd_ack) begin
                        req_q     <= 1'b0;
                        ready_q   <= 1'b1;
                        beatCnt_q <= '0;
                        state_q   <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (i_dma_rd_valid) begin
                        if (beatCnt_q == lastBeat) begin
                            ready_q <= 1'b0;
                            state_q <= ST_SOF;
                        end else begin
                            beatCnt_q <= beatCnt_q + 7'd1;
                        end
                    end
                end

                ST_SOF: begin
                    txd_q   <= SOF_WORD;
                    tkmsb_q <= 1'b1;
                    tklsb_q <= 1'b1;
                    word_q  <= 9'd1;
                    state_q <= ST_HDR;
                end

                ST_HDR: begin
                    txd_q   <= hdrWord;
                    tklsb_q <= 1'b0;
                    word_q  <= word_q + 9'd1;
                    if (word_q == LAST_HDR_WORD) begin
                        state_q <= ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    txd_q   <= payValid ? laneWord : 16'h0000;
                    tklsb_q <= 1'b0;
                    word_q  <= word_q + 9'd1;
                    if (word_q == LAST_PAY_WORD) begin
                        state_q <= ST_EOF;
                    end
                end

                ST_EOF: begin
                    txd_q      <= EOF_WORD;
                    tkmsb_q    <= 1'b1;
                    tklsb_q    <= 1'b1;
                    frameCnt_q <= frameCnt_q + 16'd1;
                    if (isTail) begin
                        irqPend_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        // The subtraction is already clamped by frameBytes,
                        // so the remainder can never wrap.
                        remBytes_q <= remBytes_q - {16'd0, curBytes};
                        addr_q     <= addr_q + ADDR_WIDTH'(FRAME_BYTES);
                        gapCnt_q   <= '0;
                        state_q    <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gapCnt_q == GAP_W'(IDLE_GAP - 1)) begin
                        req_q     <= 1'b1;
                        cmdData_q <= nextCmd_d;
                        state_q   <= ST_CMD;
                    end else begin
                        gapCnt_q <= gapCnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_cmd_req   = req_q;
    assign o_rd_cmd_data  = cmdData_q;
    assign o_dma_rd_ready = ready_q;
    assign o_tx_busy      = busy_q;
    assign o_tx_interrupt = irq_q;
    assign o_tx_frame_cnt = frameCnt_q;
    assign o_2711_tkmsb   = tkmsb_q;
    assign o_2711_tklsb   = tklsb_q;
    assign o_2711_txd     = txd_q;

endmodule

// File: tb/tb_tlk2711_tx_link.sv
// ---------------------------------------------------------------------------
// tb_tlk2711_tx_link
//
// Directed bench for tlk2711_tx_link. A small DMA responder acks each read
// command and returns beats whose contents are a function of byte address,
// so every payload word the link should send can be worked out here from the
// packet base, frame index and valid length alone.
// ---------------------------------------------------------------------------
module tb_tlk2711_tx_link;

    localparam int IDLE_GAP = 8;
    localparam logic [17:0] SOF18  = {2'b11, 16'h5CFB};
    localparam logic [17:0] IDLE18 = {2'b01, 16'hC5BC};

    logic        clk;
    logic        rst_n;
    logic        softRst;
    logic        txStart;
    logic [31:0] txBaseAddr;
    logic [31:0] txPacketLen;
    logic        rdCmdReq;
    logic        rdCmdAck;
    logic [47:0] rdCmdData;
    logic        dmaRdValid;
    logic        dmaRdReady;
    logic [63:0] dmaRdData;
    logic        txBusy;
    logic        txInterrupt;
    logic [15:0] txFrameCnt;
    logic        tkmsb;
    logic        tklsb;
    logic [15:0] txd;

    int          checkCount  = 0;
    int          errorCount  = 0;
    int          cyc         = 0;
    int          irqCount    = 0;
    int          lastBeatCyc = 0;
    int          sofCyc      = 0;
    bit          toggleMode  = 1'b0;
    logic [47:0] cmdQ [$];

    tlk2711_tx_link #(
        .ADDR_WIDTH (32),
        .DLEN_WIDTH (16),
        .DATA_WIDTH (64),
        .IDLE_GAP   (IDLE_GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_soft_rst      (softRst),
        .i_tx_start      (txStart),
        .i_tx_base_addr  (txBaseAddr),
        .i_tx_packet_len (txPacketLen),
        .o_rd_cmd_req    (rdCmdReq),
        .i_rd_cmd_ack    (rdCmdAck),
        .o_rd_cmd_data   (rdCmdData),
        .i_dma_rd_valid  (dmaRdValid),
        .o_dma_rd_ready  (dmaRdReady),
        .i_dma_rd_data   (dmaRdData),
        .o_tx_busy       (txBusy),
        .o_tx_interrupt  (txInterrupt),
        .o_tx_frame_cnt  (txFrameCnt),
        .o_2711_tkmsb    (tkmsb),
        .o_2711_tklsb    (tklsb),
        .o_2711_txd      (txd)
    );

    // 100 MHz link clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle number, used to measure fetch-to-SOF latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Interrupt pulse counter
    always @(posedge clk) begin
        if (txInterrupt === 1'b1) begin
            irqCount <= irqCount + 1;
        end
    end

    // Stop a hung run with a visible failure instead of spinning forever
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] wordAt(input logic [31:0] a);
        return 16'((a >> 1) + 32'h1000);
    endfunction

    function automatic logic [63:0] beatAt(input logic [31:0] a);
        return {wordAt(a + 32'd6), wordAt(a + 32'd4), wordAt(a + 32'd2), wordAt(a)};
    endfunction

    // Expected {tkmsb, tklsb, txd} for word k of a frame
    function automatic logic [17:0] expWord(input int fidx, input int nBytes, input bit isTail,
                                            input logic [31:0] pktBase, input int k);
        int p;
        if (k == 0)   return SOF18;
        if (k == 442) return {2'b11, 16'hFDFE};
        if (k == 1)   return {2'b00, 16'(fidx)};
        if (k == 3)   return {2'b00, (isTail ? 16'h0100 : 16'h0000)};
        if (k == 5)   return {2'b00, 16'(nBytes)};
        if (k < 6)    return 18'h0;
        p = k - 6;
        if (2 * p < nBytes) return {2'b00, wordAt(pktBase + 32'(872 * fidx + 2 * p))};
        return 18'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle; returns at the cycle after the pulse
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] len);
        @(negedge clk);
        txBaseAddr  = base;
        txPacketLen = len;
        txStart     = 1'b1;
        @(negedge clk);
        txStart     = 1'b0;
    endtask

    task automatic checkCmd(input string tag, input int idx, input logic [31:0] expAddr, input logic [15:0] expLen);
        if (idx < cmdQ.size()) checkOutput(tag, {16'd0, cmdQ[idx]}, {16'd0, expAddr, expLen});
        else                   checkOutput(tag, 64'hFFFF_FFFF_FFFF_FFFF, {16'd0, expAddr, expLen});
    endtask

    // Wait for the next SOF, then check the whole 443-word frame word by
    // word, the frame counter, and the cycle right after EOF.
    task automatic checkFrame(input int fidx, input int nBytes, input bit isTail,
                              input logic [31:0] pktBase, input bit checkGap);
        int waitCnt;
        int idleCnt;
        waitCnt = 0;
        idleCnt = 0;
        while ({tkmsb, tklsb, txd} != SOF18 && waitCnt < 3000) begin
            if ({tkmsb, tklsb, txd} == IDLE18) idleCnt++;
            @(negedge clk);
            waitCnt++;
        end
        checkOutput($sformatf("f%0d_sof_seen", fidx), 64'(waitCnt < 3000), 64'd1);
        if (waitCnt >= 3000) return;
        sofCyc = cyc;
        checkOutput($sformatf("f%0d_sof_latency", fidx), 64'(sofCyc - lastBeatCyc), 64'd2);
        if (checkGap) checkOutput($sformatf("f%0d_gap_min", fidx), 64'(idleCnt >= IDLE_GAP), 64'd1);
        checkOutput($sformatf("f%0d_cnt_at_sof", fidx), 64'(txFrameCnt), 64'(fidx));
        for (int k = 0; k < 443; k++) begin
            checkOutput($sformatf("f%0d_w%0d", fidx, k), 64'({tkmsb, tklsb, txd}),
                        64'(expWord(fidx, nBytes, isTail, pktBase, k)));
            if (k == 442) checkOutput($sformatf("f%0d_cnt_at_eof", fidx), 64'(txFrameCnt), 64'(fidx + 1));
            @(negedge clk);
        end
        checkOutput($sformatf("f%0d_post_eof_idle", fidx), 64'({tkmsb, tklsb, txd}), 64'(IDLE18));
        checkOutput($sformatf("f%0d_irq", fidx), 64'(txInterrupt), 64'(isTail));
        checkOutput($sformatf("f%0d_busy_after", fidx), 64'(txBusy), 64'(!isTail));
        if (isTail) begin
            @(negedge clk);
            checkOutput($sformatf("f%0d_irq_one_cycle", fidx), 64'(txInterrupt), 64'd0);
        end
    endtask

    // DMA model: ack each command immediately, then hand over byte_len/8
    // beats, optionally with valid dropping every other cycle.
    initial begin : dmaResponder
        logic [31:0] cmdAddr;
        int          nBeats;
        int          beatIdx;
        int          guard;
        bit          phase;
        bit          readyNow;
        rdCmdAck   = 1'b0;
        dmaRdValid = 1'b0;
        dmaRdData  = '0;
        forever begin
            @(negedge clk);
            if (rdCmdReq === 1'b1) begin
                cmdQ.push_back(rdCmdData);
                cmdAddr  = rdCmdData[47:16];
                nBeats   = int'(rdCmdData[15:0]) / 8;
                rdCmdAck = 1'b1;
                @(negedge clk);
                rdCmdAck = 1'b0;
                checkOutput("req_drop_after_ack", 64'(rdCmdReq), 64'd0);
                beatIdx = 0;
                guard   = 0;
                phase   = 1'b0;
                while (beatIdx < nBeats && guard < 1000) begin
                    if (toggleMode && phase) begin
                        dmaRdValid = 1'b0;
                    end else begin
                        dmaRdValid = 1'b1;
                        dmaRdData  = beatAt(cmdAddr + 32'(8 * beatIdx));
                    end
                    phase    = !phase;
                    readyNow = dmaRdReady;
                    if (dmaRdValid && readyNow) begin
                        lastBeatCyc = cyc;
                        beatIdx++;
                    end
                    guard++;
                    @(negedge clk);
                end
                dmaRdValid = 1'b0;
                checkOutput("dma_beats_done", 64'(beatIdx), 64'(nBeats));
            end
        end
    end

    // Directed test sequence
    initial begin
        rst_n       = 1'b1;
        softRst     = 1'b0;
        txStart     = 1'b0;
        txBaseAddr  = '0;
        txPacketLen = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        checkOutput("rst_tx_word", 64'({tkmsb, tklsb, txd}), 64'(IDLE18));
        checkOutput("rst_req",     64'(rdCmdReq),    64'd0);
        checkOutput("rst_cmd",     64'(rdCmdData),   64'd0);
        checkOutput("rst_ready",   64'(dmaRdReady),  64'd0);
        checkOutput("rst_busy",    64'(txBusy),      64'd0);
        checkOutput("rst_irq",     64'(txInterrupt), 64'd0);
        checkOutput("rst_cnt",     64'(txFrameCnt),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single short tail frame: 16 bytes at 0x1000
        $display("[TB] test 1: len=16");
        cmdQ.delete();
        applyStimulus(32'h1000, 32'd16);
        checkOutput("t1_busy_rise", 64'(txBusy),   64'd1);
        checkOutput("t1_req_rise",  64'(rdCmdReq), 64'd1);
        checkFrame(0, 16, 1'b1, 32'h1000, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("t1_cmd_count", 64'(cmdQ.size()), 64'd1);
        checkCmd("t1_cmd0", 0, 32'h1000, 16'd16);
        checkOutput("t1_irq_count", 64'(irqCount),   64'd1);
        checkOutput("t1_frame_cnt", 64'(txFrameCnt), 64'd1);

        // Zero length start does nothing
        $display("[TB] test 2: len=0");
        applyStimulus(32'h7000, 32'd0);
        checkOutput("t2_busy", 64'(txBusy),   64'd0);
        checkOutput("t2_req",  64'(rdCmdReq), 64'd0);
        repeat (10) @(negedge clk);
        checkOutput("t2_cmd_count", 64'(cmdQ.size()), 64'd1);
        checkOutput("t2_tx_word",   64'({tkmsb, tklsb, txd}), 64'(IDLE18));
        checkOutput("t2_frame_cnt", 64'(txFrameCnt), 64'd1);
        checkOutput("t2_irq_count", 64'(irqCount),   64'd1);

        // Three-frame packet, with a start pulse while busy that must be ignored
        $display("[TB] test 3: len=1748");
        cmdQ.delete();
        applyStimulus(32'h4000, 32'd1748);
        checkOutput("t3_busy_rise", 64'(txBusy), 64'd1);
        applyStimulus(32'h9000, 32'd16);
        checkFrame(0, 872, 1'b0, 32'h4000, 1'b0);
        checkFrame(1, 872, 1'b0, 32'h4000, 1'b1);
        checkFrame(2, 4,   1'b1, 32'h4000, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("t3_cmd_count", 64'(cmdQ.size()), 64'd3);
        checkCmd("t3_cmd0", 0, 32'h4000, 16'd872);
        checkCmd("t3_cmd1", 1, 32'h4368, 16'd872);
        checkCmd("t3_cmd2", 2, 32'h46D0, 16'd8);
        checkOutput("t3_irq_count", 64'(irqCount),   64'd2);
        checkOutput("t3_frame_cnt", 64'(txFrameCnt), 64'd3);

        // Odd length: 5 bytes, one beat, three data words
        $display("[TB] test 4: len=5");
        cmdQ.delete();
        applyStimulus(32'h3000, 32'd5);
        checkFrame(0, 5, 1'b1, 32'h3000, 1'b0);
        repeat (2) @(negedge clk);
        checkCmd("t4_cmd0", 0, 32'h3000, 16'd8);
        checkOutput("t4_irq_count", 64'(irqCount), 64'd3);

        // Gappy read data: valid every other cycle
        $display("[TB] test 5: len=100, valid toggling");
        cmdQ.delete();
        toggleMode = 1'b1;
        applyStimulus(32'h5000, 32'd100);
        checkFrame(0, 100, 1'b1, 32'h5000, 1'b0);
        toggleMode = 1'b0;
        repeat (2) @(negedge clk);
        checkCmd("t5_cmd0", 0, 32'h5000, 16'd104);
        checkOutput("t5_irq_count", 64'(irqCount), 64'd4);

        // Async reset in the middle of a payload, then a fresh packet
        $display("[TB] test 6: reset mid-payload");
        cmdQ.delete();
        applyStimulus(32'h6000, 32'd1748);
        begin
            int waitCnt;
            waitCnt = 0;
            while ({tkmsb, tklsb, txd} != SOF18 && waitCnt < 3000) begin
                @(negedge clk);
                waitCnt++;
            end
            checkOutput("t6_sof_seen", 64'(waitCnt < 3000), 64'd1);
        end
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_tx_word", 64'({tkmsb, tklsb, txd}), 64'(IDLE18));
        checkOutput("t6_rst_busy",    64'(txBusy),      64'd0);
        checkOutput("t6_rst_req",     64'(rdCmdReq),    64'd0);
        checkOutput("t6_rst_cmd",     64'(rdCmdData),   64'd0);
        checkOutput("t6_rst_ready",   64'(dmaRdReady),  64'd0);
        checkOutput("t6_rst_irq",     64'(txInterrupt), 64'd0);
        checkOutput("t6_rst_cnt",     64'(txFrameCnt),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_irq_count", 64'(irqCount), 64'd4);
        cmdQ.delete();
        applyStimulus(32'h2000, 32'd16);
        checkFrame(0, 16, 1'b1, 32'h2000, 1'b0);
        repeat (2) @(negedge clk);
        checkCmd("t6_cmd0", 0, 32'h2000, 16'd16);
        checkOutput("t6_irq_count_after", 64'(irqCount),   64'd5);
        checkOutput("t6_frame_cnt",       64'(txFrameCnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
